// File: rtl/ngy_grid_pkg.sv
// Shared layout and raster defaults for the snake grid. The game logic and
// the scanout both import this so they agree on the cell count and indexing.
package ngy_grid_pkg;

  // Grid layout: cell (r,c) lives at bit r*NGY_GRID_COLS+c.
  localparam int NGY_GRID_ROWS  = 30;
  localparam int NGY_GRID_COLS  = 40;
  localparam int NGY_GRID_CELLS = NGY_GRID_ROWS * NGY_GRID_COLS;
  localparam int NGY_CELL_SHIFT = 3;

  // Default raster timing (pixels / lines) and pixel clock divider.
  localparam int NGY_CLK_DIV = 12;
  localparam int NGY_H_FP    = 16;
  localparam int NGY_H_SYNC  = 32;
  localparam int NGY_H_BP    = 32;
  localparam int NGY_V_FP    = 3;
  localparam int NGY_V_SYNC  = 4;
  localparam int NGY_V_BP    = 13;

  // Default palette.
  localparam logic [23:0] NGY_ON_RGB   = 24'h00FF00;
  localparam logic [23:0] NGY_OFF_RGB  = 24'h000000;
  localparam logic [23:0] NGY_LINE_RGB = 24'h202020;

  // Per-pixel flags carried alongside the cell index through the pipeline.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic grid_edge;
    logic first;
  } scan_flags_t;

endpackage

// File: rtl/ngy_video_timing.sv
// Raster timing generator: pixel clock-enable divider, h/v counters and the
// combinational de/hs/vs/vblank_start decodes of the current counter values.
module ngy_video_timing
  import ngy_grid_pkg::*;
#(
  parameter int CLK_DIV  = NGY_CLK_DIV,
  parameter int H_ACTIVE = NGY_GRID_COLS << NGY_CELL_SHIFT,
  parameter int H_FP     = NGY_H_FP,
  parameter int H_SYNC   = NGY_H_SYNC,
  parameter int H_BP     = NGY_H_BP,
  parameter int V_ACTIVE = NGY_GRID_ROWS << NGY_CELL_SHIFT,
  parameter int V_FP     = NGY_V_FP,
  parameter int V_SYNC   = NGY_V_SYNC,
  parameter int V_BP     = NGY_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HCNT_W  = $clog2(H_TOTAL),
  localparam int VCNT_W  = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              pix_ce,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              de,
  output logic              hs,
  output logic              vs,
  output logic              vblank_start
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ONE    = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] H_ACT_C  = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ONE    = VCNT_W'(1);
  localparam logic [VCNT_W-1:0] V_ACT_C  = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VB_LINE  = VCNT_W'(V_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]  div_q,  div_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  assign pix_ce = (div_q == DIV_LAST);
  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign de     = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  assign hs     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vs     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  // True on the strobe that moves the raster to (0, V_ACTIVE).
  assign vblank_start = pix_ce && (hcnt_q == H_LAST) && (vcnt_q == VB_LINE);

  // Next divider and raster counter values; counters move only on pix_ce.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + V_ONE;
      end else begin
        hcnt_d = hcnt_q + H_ONE;
      end
    end
  end

  // Divider and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/ngy_grid_scanout.sv
// Rasterises the one-bit snake grid into a 24-bit video stream. The grid is
// copied into a shadow once per frame at the start of vblank, so the visible
// picture never tears. Two pix_ce stages: S1 = cell index + flags, S2 = colour.
module ngy_grid_scanout
  import ngy_grid_pkg::*;
#(
  parameter int          GRID_ROWS  = NGY_GRID_ROWS,
  parameter int          GRID_COLS  = NGY_GRID_COLS,
  parameter int          CELL_SHIFT = NGY_CELL_SHIFT,
  parameter int          CLK_DIV    = NGY_CLK_DIV,
  parameter int          H_FP       = NGY_H_FP,
  parameter int          H_SYNC     = NGY_H_SYNC,
  parameter int          H_BP       = NGY_H_BP,
  parameter int          V_FP       = NGY_V_FP,
  parameter int          V_SYNC     = NGY_V_SYNC,
  parameter int          V_BP       = NGY_V_BP,
  parameter logic [23:0] ON_RGB     = NGY_ON_RGB,
  parameter logic [23:0] OFF_RGB    = NGY_OFF_RGB,
  parameter logic [23:0] LINE_RGB   = NGY_LINE_RGB,
  parameter int          SHOW_GRID  = 1
) (
  input  logic                             clk_74a,
  input  logic                             reset_n,
  input  logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  output logic                             pix_ce,
  output logic [23:0]                      video_rgb,
  output logic                             video_de,
  output logic                             video_hs,
  output logic                             video_vs,
  output logic                             frame_start
);

  localparam int CELLS    = GRID_ROWS * GRID_COLS;
  localparam int H_ACTIVE = GRID_COLS << CELL_SHIFT;
  localparam int V_ACTIVE = GRID_ROWS << CELL_SHIFT;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCNT_W   = $clog2(H_TOTAL);
  localparam int VCNT_W   = $clog2(V_TOTAL);
  // Wide enough for row_base plus any hcnt column, even outside active area.
  localparam int IDX_W    = $clog2(CELLS + (H_TOTAL >> CELL_SHIFT) + 1);
  localparam int CELL_W   = $clog2(CELLS);

  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ONE   = VCNT_W'(1);
  localparam logic [VCNT_W-1:0] V_ACT_C = VCNT_W'(V_ACTIVE);
  localparam logic [IDX_W-1:0]  COLS_C  = IDX_W'(GRID_COLS);
  localparam logic [IDX_W-1:0]  IDX_LIM = IDX_W'(CELLS);

  logic              tm_de, tm_hs, tm_vs, vblank_start;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic [VCNT_W-1:0] vcnt_nxt;

  logic [0:CELLS-1]  shadow_q,   shadow_d;
  logic [IDX_W-1:0]  row_base_q, row_base_d;
  logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
  scan_flags_t       s1_flags_q, s1_flags_d;
  logic              lit;
  logic [23:0]       rgb_sel;
  logic [23:0]       rgb_q,  rgb_d;
  logic              de_q,   de_d;
  logic              hs_q,   hs_d;
  logic              vs_q,   vs_d;
  logic              fs_q,   fs_d;

  ngy_video_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk_74a),
    .rst_n        (reset_n),
    .pix_ce       (pix_ce),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .de           (tm_de),
    .hs           (tm_hs),
    .vs           (tm_vs),
    .vblank_start (vblank_start)
  );

  // Shadow capture at vblank start and row_base tracking of the cell row.
  always_comb begin
    shadow_d   = vblank_start ? grid_ram : shadow_q;
    row_base_d = row_base_q;
    vcnt_nxt   = (vcnt == V_LAST) ? '0 : vcnt + V_ONE;
    if (pix_ce && (hcnt == H_LAST)) begin
      if (vcnt_nxt == '0) begin
        row_base_d = '0;
      end else if ((vcnt_nxt[CELL_SHIFT-1:0] == '0) && (vcnt_nxt < V_ACT_C)) begin
        row_base_d = row_base_q + COLS_C;
      end
    end
  end

  // Stage 1: cell index (row_base + column) and position flags.
  always_comb begin
    s1_idx_d   = s1_idx_q;
    s1_flags_d = s1_flags_q;
    if (pix_ce) begin
      s1_idx_d             = row_base_q + IDX_W'(hcnt >> CELL_SHIFT);
      s1_flags_d.de        = tm_de;
      s1_flags_d.hs        = tm_hs;
      s1_flags_d.vs        = tm_vs;
      s1_flags_d.grid_edge = (hcnt[CELL_SHIFT-1:0] == '0) ||
                             (vcnt[CELL_SHIFT-1:0] == '0);
      s1_flags_d.first     = (hcnt == '0) && (vcnt == '0);
    end
  end

  // Stage 2: shadow lookup and colour priority (blank, grid line, lit, unlit).
  always_comb begin
    lit = 1'b0;
    if (s1_idx_q < IDX_LIM) begin
      lit = shadow_q[s1_idx_q[CELL_W-1:0]];
    end
    if (!s1_flags_q.de) begin
      rgb_sel = 24'h000000;
    end else if ((SHOW_GRID != 0) && s1_flags_q.grid_edge) begin
      rgb_sel = LINE_RGB;
    end else if (lit) begin
      rgb_sel = ON_RGB;
    end else begin
      rgb_sel = OFF_RGB;
    end
    rgb_d = rgb_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = fs_q;
    if (pix_ce) begin
      rgb_d = rgb_sel;
      de_d  = s1_flags_q.de;
      hs_d  = s1_flags_q.hs;
      vs_d  = s1_flags_q.vs;
      fs_d  = s1_flags_q.first;
    end
  end

  // All scanout state; async reset clears outputs and the shadow.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      row_base_q <= '0;
      s1_idx_q   <= '0;
      s1_flags_q <= '0;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      row_base_q <= row_base_d;
      s1_idx_q   <= s1_idx_d;
      s1_flags_q <= s1_flags_d;
      rgb_q      <= rgb_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
    end
  end

  assign video_rgb   = rgb_q;
  assign video_de    = de_q;
  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign frame_start = fs_q;

endmodule
